// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: two combinational read ports, one write port,
// and the issue-stage scoreboard controls (reserve / flush / any_busy).
interface register_file_sb_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
);
  logic [IDX_W-1:0] reg1_index;
  logic [IDX_W-1:0] reg2_index;
  logic [WIDTH-1:0] reg1_data;
  logic [WIDTH-1:0] reg2_data;
  logic             reg1_busy;
  logic             reg2_busy;
  logic             write_en;
  logic [IDX_W-1:0] write_index;
  logic [WIDTH-1:0] write_data;
  logic             reserve_en;
  logic [IDX_W-1:0] reserve_index;
  logic             flush;
  logic             any_busy;

  modport master (
    output reg1_index, reg2_index, write_en, write_index, write_data,
           reserve_en, reserve_index, flush,
    input  reg1_data, reg2_data, reg1_busy, reg2_busy, any_busy
  );

  modport slave (
    input  reg1_index, reg2_index, write_en, write_index, write_data,
           reserve_en, reserve_index, flush,
    output reg1_data, reg2_data, reg1_busy, reg2_busy, any_busy
  );
endinterface

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with write-through bypass and a per-register
// busy scoreboard (reserve at issue, clear on writeback, flush clears all).
module register_file_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int IDX_W    = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  register_file_sb_if.slave   rf
);

  if (IDX_W != $clog2(DEPTH)) begin : g_bad_idx_w
    $error("register_file_sb: IDX_W must equal log2(DEPTH)");
  end

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_ok;
  logic rsv_ok;

  function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Bypass the in-flight write so a consumer in the writeback cycle sees it.
  function automatic logic [WIDTH-1:0] rd_data(input logic [IDX_W-1:0] idx);
    if (is_zero_reg(idx))                      return '0;
    else if (wr_ok && (rf.write_index == idx)) return rf.write_data;
    else                                       return regs_q[idx];
  endfunction

  // A same-cycle write retires the pending mark; a same-cycle reserve is not visible yet.
  function automatic logic rd_busy(input logic [IDX_W-1:0] idx);
    if (is_zero_reg(idx))                      return 1'b0;
    else if (wr_ok && (rf.write_index == idx)) return 1'b0;
    else                                       return busy_q[idx];
  endfunction

  always_comb begin
    wr_ok  = rf.write_en   && !is_zero_reg(rf.write_index);
    rsv_ok = rf.reserve_en && !is_zero_reg(rf.reserve_index);
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[rf.write_index] = rf.write_data;
      busy_d[rf.write_index] = 1'b0;
    end
    // Flush beats reserve; reserve beats a same-index writeback.
    if (rf.flush) begin
      busy_d = '0;
    end else if (rsv_ok) begin
      busy_d[rf.reserve_index] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Outputs are forced low while reset is held, including the bypass path.
  always_comb begin
    rf.reg1_data = rst_n ? rd_data(rf.reg1_index) : '0;
    rf.reg2_data = rst_n ? rd_data(rf.reg2_index) : '0;
    rf.reg1_busy = rst_n & rd_busy(rf.reg1_index);
    rf.reg2_busy = rst_n & rd_busy(rf.reg2_index);
    rf.any_busy  = rst_n & (|busy_q);
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: DUT0 has a hardwired r0, DUT1 has an
// ordinary r0; both see identical stimulus.
module tb_register_file_sb;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IDX_W-1:0] r1_idx, r2_idx, w_idx, rs_idx;
  logic [WIDTH-1:0] w_data;
  logic w_en, rs_en, fl;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  register_file_sb_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus0 ();
  register_file_sb_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus1 ();

  assign bus0.reg1_index = r1_idx;  assign bus1.reg1_index = r1_idx;
  assign bus0.reg2_index = r2_idx;  assign bus1.reg2_index = r2_idx;
  assign bus0.write_en = w_en;      assign bus1.write_en = w_en;
  assign bus0.write_index = w_idx;  assign bus1.write_index = w_idx;
  assign bus0.write_data = w_data;  assign bus1.write_data = w_data;
  assign bus0.reserve_en = rs_en;   assign bus1.reserve_en = rs_en;
  assign bus0.reserve_index = rs_idx; assign bus1.reserve_index = rs_idx;
  assign bus0.flush = fl;           assign bus1.flush = fl;

  register_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rf(bus0.slave));
  register_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rf(bus1.slave));

  task automatic idle();
    w_en = 1'b0; w_idx = '0; w_data = '0;
    rs_en = 1'b0; rs_idx = '0; fl = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    r1_idx = 5'd5; r2_idx = 5'd5;
    w_en = 1'b1; w_idx = 5'd5; w_data = 16'hCAFE;
    rs_en = 1'b1; rs_idx = 5'd5;
    #2;
    total_cnt++;
    if (bus0.reg1_data !== 16'h0) $display("FAIL rst_reg1_data got %h exp %h", bus0.reg1_data, 16'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus0.reg2_data !== 16'h0) $display("FAIL rst_reg2_data got %h exp %h", bus0.reg2_data, 16'h0);
    else pass_cnt++;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.reg2_busy, bus0.any_busy} !== 3'b000)
      $display("FAIL rst_busy got %b exp %b", {bus0.reg1_busy, bus0.reg2_busy, bus0.any_busy}, 3'b000);
    else pass_cnt++;
    tick();
    idle();
    #2 rst_n = 1'b1;
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'h0) $display("FAIL rst_write_ignored got %h exp %h", bus0.reg1_data, 16'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus0.any_busy !== 1'b0) $display("FAIL rst_reserve_ignored got %b exp %b", bus0.any_busy, 1'b0);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write_read();
    idle();
    w_en = 1'b1; w_idx = 5'd5; w_data = 16'hBEEF;
    r1_idx = 5'd1; r2_idx = 5'd2;
    tick();
    idle();
    r1_idx = 5'd5; r2_idx = 5'd5;
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'hBEEF) $display("FAIL wr_reg1_data got %h exp %h", bus0.reg1_data, 16'hBEEF);
    else pass_cnt++;
    total_cnt++;
    if (bus0.reg2_data !== 16'hBEEF) $display("FAIL wr_reg2_data got %h exp %h", bus0.reg2_data, 16'hBEEF);
    else pass_cnt++;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.reg2_busy} !== 2'b00)
      $display("FAIL wr_busy got %b exp %b", {bus0.reg1_busy, bus0.reg2_busy}, 2'b00);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_bypass();
    idle();
    w_en = 1'b1; w_idx = 5'd7; w_data = 16'h1234;
    r1_idx = 5'd7; r2_idx = 5'd8;
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'h1234) $display("FAIL byp_reg1_data got %h exp %h", bus0.reg1_data, 16'h1234);
    else pass_cnt++;
    total_cnt++;
    if (bus0.reg2_data !== 16'h0) $display("FAIL byp_other_port got %h exp %h", bus0.reg2_data, 16'h0);
    else pass_cnt++;
    tick();
    idle();
    r2_idx = 5'd7;
    #1;
    total_cnt++;
    if (bus0.reg2_data !== 16'h1234) $display("FAIL byp_stored got %h exp %h", bus0.reg2_data, 16'h1234);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    idle();
    rs_en = 1'b1; rs_idx = 5'd3;
    r1_idx = 5'd3; r2_idx = 5'd4;
    #1;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.any_busy} !== 2'b00)
      $display("FAIL sb_reserve_same_cycle got %b exp %b", {bus0.reg1_busy, bus0.any_busy}, 2'b00);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.reg2_busy, bus0.any_busy} !== 3'b101)
      $display("FAIL sb_reserved got %b exp %b", {bus0.reg1_busy, bus0.reg2_busy, bus0.any_busy}, 3'b101);
    else pass_cnt++;
    w_en = 1'b1; w_idx = 5'd3; w_data = 16'h00AA;
    #1;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.any_busy} !== 2'b01)
      $display("FAIL sb_wb_busy_bypass got %b exp %b", {bus0.reg1_busy, bus0.any_busy}, 2'b01);
    else pass_cnt++;
    total_cnt++;
    if (bus0.reg1_data !== 16'h00AA) $display("FAIL sb_wb_data got %h exp %h", bus0.reg1_data, 16'h00AA);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.any_busy} !== 2'b00)
      $display("FAIL sb_after_wb got %b exp %b", {bus0.reg1_busy, bus0.any_busy}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_reserve_wins_and_flush();
    idle();
    rs_en = 1'b1; rs_idx = 5'd9;
    w_en = 1'b1; w_idx = 5'd9; w_data = 16'h5555;
    r1_idx = 5'd9;
    tick();
    idle();
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'h5555) $display("FAIL rw_data got %h exp %h", bus0.reg1_data, 16'h5555);
    else pass_cnt++;
    total_cnt++;
    if (bus0.reg1_busy !== 1'b1) $display("FAIL rw_busy got %b exp %b", bus0.reg1_busy, 1'b1);
    else pass_cnt++;
    // Flush together with a reserve of r10 and a write to r11.
    fl = 1'b1; rs_en = 1'b1; rs_idx = 5'd10;
    w_en = 1'b1; w_idx = 5'd11; w_data = 16'h7777;
    #1;
    total_cnt++;
    if (bus0.any_busy !== 1'b1) $display("FAIL fl_before_edge got %b exp %b", bus0.any_busy, 1'b1);
    else pass_cnt++;
    tick();
    idle();
    r1_idx = 5'd10; r2_idx = 5'd11;
    #1;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.any_busy} !== 2'b00)
      $display("FAIL fl_cleared got %b exp %b", {bus0.reg1_busy, bus0.any_busy}, 2'b00);
    else pass_cnt++;
    total_cnt++;
    if (bus0.reg2_data !== 16'h7777) $display("FAIL fl_write_kept got %h exp %h", bus0.reg2_data, 16'h7777);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    idle();
    w_en = 1'b1; w_idx = 5'd0; w_data = 16'hFFFF;
    rs_en = 1'b1; rs_idx = 5'd0;
    r1_idx = 5'd0; r2_idx = 5'd0;
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'h0) $display("FAIL z0_no_bypass got %h exp %h", bus0.reg1_data, 16'h0);
    else pass_cnt++;
    total_cnt++;
    if (bus1.reg1_data !== 16'hFFFF) $display("FAIL z1_bypass got %h exp %h", bus1.reg1_data, 16'hFFFF);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'h0) $display("FAIL z0_data got %h exp %h", bus0.reg1_data, 16'h0);
    else pass_cnt++;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.any_busy} !== 2'b00)
      $display("FAIL z0_busy got %b exp %b", {bus0.reg1_busy, bus0.any_busy}, 2'b00);
    else pass_cnt++;
    total_cnt++;
    if (bus1.reg2_data !== 16'hFFFF) $display("FAIL z1_data got %h exp %h", bus1.reg2_data, 16'hFFFF);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    idle();
    fl = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      w_en = 1'b1; w_idx = IDX_W'(i + 1); w_data = vals[i];
      if (i == 3) begin rs_en = 1'b1; rs_idx = 5'd2; end
      tick();
    end
    idle();
    r1_idx = 5'd1; r2_idx = 5'd2;
    #1;
    total_cnt++;
    if ({bus0.reg1_data, bus0.reg2_busy} !== {16'h1111, 1'b1})
      $display("FAIL rm_pre got %h/%b exp %h/%b", bus0.reg1_data, bus0.reg2_busy, 16'h1111, 1'b1);
    else pass_cnt++;
    w_en = 1'b1; w_idx = 5'd4; w_data = 16'h9999;
    rs_en = 1'b1; rs_idx = 5'd6;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus0.reg1_data, bus0.reg2_data} !== 32'h0)
      $display("FAIL rm_data got %h/%h exp 0/0", bus0.reg1_data, bus0.reg2_data);
    else pass_cnt++;
    total_cnt++;
    if ({bus0.reg1_busy, bus0.reg2_busy, bus0.any_busy} !== 3'b000)
      $display("FAIL rm_busy got %b exp %b", {bus0.reg1_busy, bus0.reg2_busy, bus0.any_busy}, 3'b000);
    else pass_cnt++;
    tick();
    idle();
    #1 rst_n = 1'b1;
    r2_idx = 5'd4;
    #1;
    total_cnt++;
    if ({bus0.reg1_data, bus0.reg2_data} !== 32'h0)
      $display("FAIL rm_after got %h/%h exp 0/0", bus0.reg1_data, bus0.reg2_data);
    else pass_cnt++;
    total_cnt++;
    if (bus0.any_busy !== 1'b0) $display("FAIL rm_after_busy got %b exp %b", bus0.any_busy, 1'b0);
    else pass_cnt++;
    w_en = 1'b1; w_idx = 5'd1; w_data = 16'hABCD;
    tick();
    idle();
    #1;
    total_cnt++;
    if (bus0.reg1_data !== 16'hABCD) $display("FAIL rm_first_edge got %h exp %h", bus0.reg1_data, 16'hABCD);
    else pass_cnt++;
  endtask

  initial begin
    r1_idx = '0; r2_idx = '0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reserve_wins_and_flush();
    test_zero_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
